// File: rtl/control_sequencer.sv
// Hardwired control sequencer for DataPath: instruction fetch followed by
// fixed T-state execution of ld, ldi, st, addi, nop and halt, with a
// memory-ready handshake on every memory access. All strobes are registered.
module control_sequencer #(
    parameter int OPW = 5
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        mem_ready,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Read,
    output logic        Write,
    output logic        IRin,
    output logic        Yin,
    output logic        Zlowin,
    output logic        Zlowout,
    output logic        Gra,
    output logic        Grb,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Csignout,
    output logic        ADD,
    output logic        run
);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef struct packed {
        logic pc_out;
        logic pc_in;
        logic inc_pc;
        logic mar_in;
        logic mdr_in;
        logic mdr_out;
        logic read;
        logic write;
        logic ir_in;
        logic y_in;
        logic zlow_in;
        logic zlow_out;
        logic gra;
        logic grb;
        logic r_in;
        logic r_out;
        logic ba_out;
        logic csign_out;
        logic add;
        logic run;
    } ctl_t;

    localparam logic [OPW-1:0] OP_LD   = OPW'(5'b00000);
    localparam logic [OPW-1:0] OP_LDI  = OPW'(5'b00001);
    localparam logic [OPW-1:0] OP_ST   = OPW'(5'b00010);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01100);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

    state_t           state, state_next;
    logic [OPW-1:0]   op, op_next;
    ctl_t             ctl;

    // Only the opcode field of IR steers the sequence; operand fields belong to DataPath.
    logic unused_ir;
    assign unused_ir = ^IR[31-OPW:0];

    // Strobe set for a given state and opcode; nop and unknown opcodes fall through to no strobes.
    function automatic ctl_t decode(input state_t s, input logic [OPW-1:0] o);
        ctl_t c;
        c     = '0;
        c.run = (s != S_RST) && (s != S_HALT);
        case (s)
            S_T0: begin
                c.pc_out  = 1'b1;
                c.mar_in  = 1'b1;
                c.inc_pc  = 1'b1;
                c.zlow_in = 1'b1;
            end
            S_T1: begin
                c.zlow_out = 1'b1;
                c.pc_in    = 1'b1;
                c.read     = 1'b1;
                c.mdr_in   = 1'b1;
            end
            S_T2: begin
                c.mdr_out = 1'b1;
                c.ir_in   = 1'b1;
            end
            S_T3: begin
                if (o == OP_LD || o == OP_LDI || o == OP_ST) begin
                    c.grb    = 1'b1;
                    c.ba_out = 1'b1;
                    c.y_in   = 1'b1;
                end else if (o == OP_ADDI) begin
                    c.grb   = 1'b1;
                    c.r_out = 1'b1;
                    c.y_in  = 1'b1;
                end
            end
            S_T4: begin
                c.csign_out = 1'b1;
                c.add       = 1'b1;
                c.zlow_in   = 1'b1;
            end
            S_T5: begin
                c.zlow_out = 1'b1;
                if (o == OP_LDI || o == OP_ADDI) begin
                    c.gra  = 1'b1;
                    c.r_in = 1'b1;
                end else begin
                    c.mar_in = 1'b1;
                end
            end
            S_T6: begin
                c.mdr_in = 1'b1;
                if (o == OP_ST) begin
                    // Read stays low so MDR loads from the bus, not from memory.
                    c.gra   = 1'b1;
                    c.r_out = 1'b1;
                end else begin
                    c.read = 1'b1;
                end
            end
            S_T7: begin
                c.mdr_out = 1'b1;
                if (o == OP_ST) begin
                    c.write = 1'b1;
                end else begin
                    c.gra  = 1'b1;
                    c.r_in = 1'b1;
                end
            end
            default: ;
        endcase
        return c;
    endfunction

    // Next state and next opcode; the opcode is latched as the sequence enters T3.
    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        state_next = state;
        op_next    = op;
        case (state)
            S_RST: state_next = S_T0;
            S_T0:  state_next = S_T1;
            S_T1:  state_next = mem_ready ? S_T2 : S_T1;
            S_T2: begin
                state_next = S_T3;
                op_next    = IR[31 -: OPW];
            end
            S_T3: begin
                if (op == OP_HALT)
                    state_next = S_HALT;
                else if (op == OP_LD || op == OP_LDI || op == OP_ST || op == OP_ADDI)
                    state_next = S_T4;
                else
                    state_next = S_T0;
            end
            S_T4: state_next = S_T5;
            S_T5: state_next = (op == OP_LD || op == OP_ST) ? S_T6 : S_T0;
            S_T6: begin
                if (op == OP_ST)
                    state_next = S_T7;
                else if (op == OP_LD)
                    state_next = mem_ready ? S_T7 : S_T6;
                else
                    state_next = S_T0;
            end
            S_T7: begin
                if (op == OP_ST)
                    state_next = mem_ready ? S_T0 : S_T7;
                else
                    state_next = S_T0;
            end
            S_HALT: state_next = S_HALT;
            default: state_next = S_RST;
        endcase
    end

    // State, opcode and strobe registers; strobes are decoded one cycle ahead so they are glitch-free.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= S_RST;
            op    <= '0;
            ctl   <= '0;
        end else begin
            // NOTE: non-blocking so every register updates from pre-edge values.
            state <= state_next;
            op    <= op_next;
            ctl   <= decode(state_next, op_next);
        end
    end

    assign PCout    = ctl.pc_out;
    assign PCin     = ctl.pc_in;
    assign IncPC    = ctl.inc_pc;
    assign MARin    = ctl.mar_in;
    assign MDRin    = ctl.mdr_in;
    assign MDRout   = ctl.mdr_out;
    assign Read     = ctl.read;
    assign Write    = ctl.write;
    assign IRin     = ctl.ir_in;
    assign Yin      = ctl.y_in;
    assign Zlowin   = ctl.zlow_in;
    assign Zlowout  = ctl.zlow_out;
    assign Gra      = ctl.gra;
    assign Grb      = ctl.grb;
    assign Rin      = ctl.r_in;
    assign Rout     = ctl.r_out;
    assign BAout    = ctl.ba_out;
    assign Csignout = ctl.csign_out;
    assign ADD      = ctl.add;
    assign run      = ctl.run;

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit that sits directly upstream of `DataPath` and drives every datapath control strobe that a bench FSM drives by hand today. It runs the instruction fetch and executes `ld`, `ldi`, `st`, `addi`, `nop` and `halt` as fixed T-state sequences. It also waits on a memory-ready handshake during every memory access. Outputs connect one-to-one to the same-named `DataPath` ports.

## Interface
- `OPW`, 5: opcode field width, taken from IR[31:27].
- `clock`  in  1: single system clock; all state changes on the rising edge.
- `clear`  in  1: asynchronous, active-low reset.
- `IR`  in  32: current instruction register contents from `DataPath`.
- `mem_ready`  in  1: memory has completed the current read or write.
- `PCout`, `PCin`, `IncPC`  out  1 each: PC strobes.
- `MARin`, `MDRin`, `MDRout`  out  1 each: memory address and data register strobes.
- `Read`, `Write`  out  1 each: memory access strobes. `Read` also selects `Mdatain` into MDR.
- `IRin`, `Yin`, `Zlowin`, `Zlowout`  out  1 each: register strobes.
- `Gra`, `Grb`, `Rin`, `Rout`, `BAout`, `Csignout`  out  1 each: register-select and immediate strobes.
- `ADD`  out  1: ALU add select.
- `run`  out  1: high while executing, low in reset and HALT.

## Operation
- Moore FSM. Outputs are decoded only from the registered state and the registered opcode `op`.
- States: RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT.
- Opcodes: `ld`=00000, `ldi`=00001, `st`=00010, `addi`=01100, `nop`=11010, `halt`=11011. Any other opcode is treated as `nop`.
- RST → T0 on the first edge after `clear` deasserts.
- T0: assert `PCout`, `MARin`, `IncPC`, `Zlowin`. Go to T1.
- T1: assert `Zlowout`, `PCin`, `Read`, `MDRin`. Stay in T1 while `mem_ready`=0; go to T2 when it is 1. Re-loading PC from Z during the wait is idempotent.
- T2: assert `MDRout`, `IRin`. Go to T3.
- T3: capture `op` = IR[31:27].
  - `nop` or unknown: no strobes; go to T0.
  - `halt`: no strobes; go to HALT.
  - `ld`, `ldi`, `st`: assert `Grb`, `BAout`, `Yin`; go to T4.
  - `addi`: assert `Grb`, `Rout`, `Yin`; go to T4.
- T4: assert `Csignout`, `ADD`, `Zlowin`. Go to T5.
- T5:
  - `ldi` or `addi`: assert `Zlowout`, `Gra`, `Rin`; go to T0.
  - `ld` or `st`: assert `Zlowout`, `MARin`; go to T6.
- T6:
  - `ld`: assert `Read`, `MDRin`. Hold while `mem_ready`=0; go to T7 when it is 1.
  - `st`: assert `Gra`, `Rout`, `MDRin` with `Read`=0, so MDR loads from the bus. Go to T7 unconditionally.
- T7:
  - `ld`: assert `MDRout`, `Gra`, `Rin`; go to T0.
  - `st`: assert `MDRout`, `Write`. Hold while `mem_ready`=0; go to T0 when it is 1.
- HALT: all strobes 0, `run`=0. Only `clear` leaves HALT.
- `op` is registered at T3. IR changes after T3 do not affect the current instruction.

## Timing
- Reset, asynchronous: state=RST, `op`=00000, every output 0 including `run`. This takes effect immediately when `clear` asserts, including mid-instruction or during a memory wait.
- `run`=1 in every state except RST and HALT.
- Outputs change only after a rising edge, or immediately on `clear` assertion. Each strobe is valid for the whole cycle.
- Cycle counts from T0 entry to the next T0, with zero-wait memory (`mem_ready` held 1):
  - `nop`: 4
  - `ldi`, `addi`: 6
  - `ld`, `st`: 8
  - Each cycle `mem_ready` is low during T1, `ld`-T6 or `st`-T7 adds one cycle.
- `mem_ready` is sampled only in T1, `ld`-T6 and `st`-T7, and ignored elsewhere. A `mem_ready` already high on entry to one of those states completes the access in one cycle.
- `Read` and `Write` are never high in the same cycle. `PCin` is high only in T1.
- There is no instruction abort. The only way to interrupt a sequence is `clear`.

## Test plan
- Reset: `clear`=0 for 2 cycles, then 1 with `mem_ready`=1 → all outputs 0 while `clear`=0; `PCout`=`MARin`=`IncPC`=`Zlowin`=1 on the first edge after release.
- Store: IR=0x10900000 (`st` R1,0(R2)), `mem_ready`=1 → states T0..T7 in 8 cycles. Strobe sets match the Operation section. `Write`=1 only in cycle 8. Next cycle is T0.
- Load with wait: IR=0x00900005 (`ld`), `mem_ready` low for 3 cycles in T6 → `Read`=`MDRin`=1 for 4 cycles; total is 11 cycles; `Gra`=`Rin`=1 in T7.
- Immediate paths: `ldi` (IR=0x08800010) and `addi` (IR=0x60900003) → each returns to T0 after 6 cycles. `ldi` asserts `BAout` in T3; `addi` asserts `Rout` instead.
- Fetch wait: `mem_ready`=0 for 5 cycles in T1 → FSM held in T1 with `PCin` high throughout. IR changed after T3 → no effect on that instruction's sequence.
- Halt and mid-operation reset: IR=0xD8000000 → HALT with `run`=0 and all strobes 0 indefinitely. Separately, `clear` pulsed during `st` T7 → outputs 0 asynchronously and fetch restarts at T0.
